pipeline_ctrl: RTL and testbench

Central pipeline control unit for the five-stage MIPS core; it produces the `stall[5:0]` vector and `flush` consumed by every stage register (pc_reg, if_id, id_ex, ex_mem, mem_wb). It arbitrates stall requests from IF, ID, EX and MEM, and turns exceptions reported by MEM into a pipeline flush plus a PC redirect. If an exception arrives while an instruction fetch is still outstanding, the unit holds PC and IF until the fetch completes, then redirects.

---
 rtl/pipeline_ctrl.sv | 137 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush control for the five-stage MIPS core.
//
// Arbitrates stall requests from IF/ID/EX/MEM into a six-bit stall vector
// (bit0 PC ... bit5 WB, 1 = hold). An exception reported by MEM flushes the
// pipeline and redirects the PC. If a fetch is still outstanding when the
// exception arrives, the redirect target is parked in r_pend_pc and the unit
// holds PC/IF (state PEND) until the fetch completes.
//
// Ports:
//   clk                clock, rising edge
//   rst                synchronous reset, active low
//   stallreq_from_if   instruction bus transaction outstanding
//   stallreq_from_id   load-use hazard
//   stallreq_from_ex   multi-cycle EX operation busy
//   stallreq_from_mem  data bus transaction outstanding
//   excepttype_i       exception code from MEM (0 = none)
//   cp0_epc_i          EPC, target of eret
//   stall              per-stage hold vector
//   flush              clear IF/ID .. MEM/WB this cycle
//   pc_redirect        PC loads new_pc
//   new_pc             redirect target (0 when pc_redirect = 0)
//   stall_cycles_o     count of cycles with PC stalled
//
// Build option: define STALL_PERF_CNT_EN to enable the saturating stall-cycle
// counter; otherwise stall_cycles_o is tied to zero.

module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles_o
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [0:0]  r_state;
  logic [0:0]  w_state_next;
  logic [31:0] r_pend_pc;
  logic [31:0] w_pend_pc_next;
  logic [31:0] w_target;

  // Redirect target decode; every nonzero code other than interrupt and eret
  // goes to the common exception vector.
  always_comb begin
    unique case (excepttype_i)
      32'h0000_0001: w_target = INT_VECTOR;
      32'h0000_000e: w_target = cp0_epc_i;
      default:       w_target = EXC_VECTOR;
    endcase
  end

  always_comb begin
    stall          = 6'b000000;
    flush          = 1'b0;
    pc_redirect    = 1'b0;
    new_pc         = 32'h0;
    w_state_next   = r_state;
    w_pend_pc_next = r_pend_pc;
    if (rst) begin
      case (r_state)
        RUN: begin
          if (excepttype_i != 32'h0) begin
            // Flush wins over every stall request.
            flush = 1'b1;
            if (!stallreq_from_if) begin
              pc_redirect = 1'b1;
              new_pc      = w_target;
            end else begin
              w_pend_pc_next = w_target;
              w_state_next   = PEND;
            end
          end else if (stallreq_from_mem) begin
            stall = 6'b011111;
          end else if (stallreq_from_ex) begin
            stall = 6'b001111;
          end else if (stallreq_from_id) begin
            stall = 6'b000111;
          end else if (stallreq_from_if) begin
            stall = 6'b000011;
          end
        end
        PEND: begin
          // Pipeline is empty here; only the outstanding fetch matters.
          if (!stallreq_from_if) begin
            pc_redirect  = 1'b1;
            new_pc       = r_pend_pc;
            w_state_next = RUN;
          end else begin
            stall = 6'b000011;
          end
        end
        default: w_state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= RUN;
      r_pend_pc <= 32'h0;
    end else begin
      r_state   <= w_state_next;
      r_pend_pc <= w_pend_pc_next;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cycles <= 32'h0;
    end else if (stall[0] && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  // Outputs read zero while reset is held.
  assign stall_cycles_o = rst ? r_stall_cycles : 32'h0;
`else
  assign stall_cycles_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_from_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic        pc_redirect;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles_o;

  int checks;
  int failures;

  pipeline_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_if (stallreq_from_if),
    .stallreq_from_id (stallreq_from_id),
    .stallreq_from_ex (stallreq_from_ex),
    .stallreq_from_mem(stallreq_from_mem),
    .excepttype_i     (excepttype_i),
    .cp0_epc_i        (cp0_epc_i),
    .stall            (stall),
    .flush            (flush),
    .pc_redirect      (pc_redirect),
    .new_pc           (new_pc),
    .stall_cycles_o   (stall_cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled
  // away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stallreq_from_if  = 1'b0;
    stallreq_from_id  = 1'b0;
    stallreq_from_ex  = 1'b0;
    stallreq_from_mem = 1'b0;
    excepttype_i      = 32'h0;
    cp0_epc_i         = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    stallreq_from_if  = 1'b1;
    stallreq_from_mem = 1'b1;
    excepttype_i      = 32'h8;
    cp0_epc_i         = 32'h1234_5678;
    #1;
    checks++;
    if ({stall, flush, pc_redirect, new_pc, stall_cycles_o} !== 72'h0) begin
      failures++;
      $display("FAIL reset_outputs: stall=%b flush=%b redir=%b new_pc=%h cnt=%h expected all 0",
               stall, flush, pc_redirect, new_pc, stall_cycles_o);
    end
    tick();
    rst = 1'b1;
    idle_inputs();
    #1;
    checks++;
    if ({stall, flush, pc_redirect, new_pc} !== 40'h0) begin
      failures++;
      $display("FAIL reset_idle: stall=%b flush=%b redir=%b new_pc=%h expected all 0",
               stall, flush, pc_redirect, new_pc);
    end
  endtask

  task automatic test_stall_priority();
    logic [3:0] req [5];
    logic [5:0] exp [5];
    // {mem, ex, id, if}
    req[0] = 4'b0011; exp[0] = 6'b000111;
    req[1] = 4'b1010; exp[1] = 6'b011111;
    req[2] = 4'b0001; exp[2] = 6'b000011;
    req[3] = 4'b0110; exp[3] = 6'b001111;
    req[4] = 4'b0000; exp[4] = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      {stallreq_from_mem, stallreq_from_ex, stallreq_from_id, stallreq_from_if} = req[i];
      #1;
      checks++;
      if (stall !== exp[i] || flush !== 1'b0 || pc_redirect !== 1'b0) begin
        failures++;
        $display("FAIL priority_%0d: stall=%b flush=%b redir=%b expected stall=%b flush=0 redir=0",
                 i, stall, flush, pc_redirect, exp[i]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_ex_stall();
    stallreq_from_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (stall !== 6'b001111 || flush !== 1'b0) begin
        failures++;
        $display("FAIL ex_stall_c%0d: stall=%b flush=%b expected 001111 flush=0", i, stall, flush);
      end
      tick();
    end
    stallreq_from_ex = 1'b0;
    #1;
    checks++;
    if (stall !== 6'b000000) begin
      failures++;
      $display("FAIL ex_stall_release: stall=%b expected 000000", stall);
    end
    tick();
  endtask

  task automatic test_exception_idle();
    logic [31:0] code [4];
    logic [31:0] tgt  [4];
    code[0] = 32'h8; tgt[0] = 32'h40;
    code[1] = 32'ha; tgt[1] = 32'h40;
    code[2] = 32'h3; tgt[2] = 32'h40;
    code[3] = 32'h1; tgt[3] = 32'h20;
    // Requests arriving with the exception must not stall.
    stallreq_from_mem = 1'b1;
    stallreq_from_id  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      excepttype_i = code[i];
      #1;
      checks++;
      if (flush !== 1'b1 || pc_redirect !== 1'b1 || new_pc !== tgt[i] || stall !== 6'b0) begin
        failures++;
        $display("FAIL exc_idle_%0h: flush=%b redir=%b new_pc=%h stall=%b expected 1 1 %h 000000",
                 code[i], flush, pc_redirect, new_pc, stall, tgt[i]);
      end
      tick();
    end
    idle_inputs();
    excepttype_i = 32'he;
    cp0_epc_i    = 32'hBFC0_0100;
    #1;
    checks++;
    if (flush !== 1'b1 || pc_redirect !== 1'b1 || new_pc !== 32'hBFC0_0100) begin
      failures++;
      $display("FAIL eret: flush=%b redir=%b new_pc=%h expected 1 1 bfc00100",
               flush, pc_redirect, new_pc);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (flush !== 1'b0 || pc_redirect !== 1'b0 || new_pc !== 32'h0) begin
      failures++;
      $display("FAIL exc_after: flush=%b redir=%b new_pc=%h expected 0 0 0",
               flush, pc_redirect, new_pc);
    end
  endtask

  task automatic test_pend();
    excepttype_i     = 32'h1;
    stallreq_from_if = 1'b1;
    #1;
    checks++;
    if (flush !== 1'b1 || pc_redirect !== 1'b0 || stall !== 6'b0 || new_pc !== 32'h0) begin
      failures++;
      $display("FAIL pend_flush: flush=%b redir=%b stall=%b new_pc=%h expected 1 0 000000 0",
               flush, pc_redirect, stall, new_pc);
    end
    tick();
    excepttype_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      // Mid-PEND: a new exception and a MEM request must both be ignored.
      excepttype_i      = (i == 1) ? 32'h8 : 32'h0;
      stallreq_from_mem = (i == 1);
      #1;
      checks++;
      if (stall !== 6'b000011 || flush !== 1'b0 || pc_redirect !== 1'b0) begin
        failures++;
        $display("FAIL pend_hold_c%0d: stall=%b flush=%b redir=%b expected 000011 0 0",
                 i, stall, flush, pc_redirect);
      end
      tick();
    end
    idle_inputs();
    #1;
    checks++;
    if (pc_redirect !== 1'b1 || new_pc !== 32'h20 || stall !== 6'b0 || flush !== 1'b0) begin
      failures++;
      $display("FAIL pend_redirect: redir=%b new_pc=%h stall=%b flush=%b expected 1 00000020 0 0",
               pc_redirect, new_pc, stall, flush);
    end
    tick();
    checks++;
    if (pc_redirect !== 1'b0 || stall !== 6'b0) begin
      failures++;
      $display("FAIL pend_done: redir=%b stall=%b expected 0 000000", pc_redirect, stall);
    end
  endtask

  task automatic test_reset_in_pend();
    excepttype_i     = 32'h8;
    stallreq_from_if = 1'b1;
    tick();
    excepttype_i = 32'h0;
    #1;
    checks++;
    if (stall !== 6'b000011) begin
      failures++;
      $display("FAIL rst_pend_entry: stall=%b expected 000011", stall);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({stall, flush, pc_redirect, new_pc} !== 40'h0) begin
      failures++;
      $display("FAIL rst_pend_outputs: stall=%b flush=%b redir=%b new_pc=%h expected all 0",
               stall, flush, pc_redirect, new_pc);
    end
    tick();
    rst = 1'b1;
    stallreq_from_if = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (pc_redirect !== 1'b0 || new_pc !== 32'h0 || stall !== 6'b0) begin
        failures++;
        $display("FAIL rst_pend_abandon_c%0d: redir=%b new_pc=%h stall=%b expected 0 0 000000",
                 i, pc_redirect, new_pc, stall);
      end
      tick();
    end
  endtask

  task automatic test_perf_cnt();
    logic [31:0] exp_cnt;
`ifdef STALL_PERF_CNT_EN
    exp_cnt = 32'd7;
`else
    exp_cnt = 32'd0;
`endif
    do_reset();
    checks++;
    if (stall_cycles_o !== 32'h0) begin
      failures++;
      $display("FAIL perf_after_reset: cnt=%0d expected 0", stall_cycles_o);
    end
    stallreq_from_ex = 1'b1;
    repeat (5) tick();
    stallreq_from_ex = 1'b0;
    excepttype_i     = 32'hc;
    stallreq_from_if = 1'b1;
    tick();
    excepttype_i = 32'h0;
    repeat (2) tick();
    stallreq_from_if = 1'b0;
    #1;
    checks++;
    if (pc_redirect !== 1'b1 || new_pc !== 32'h40) begin
      failures++;
      $display("FAIL perf_redirect: redir=%b new_pc=%h expected 1 00000040", pc_redirect, new_pc);
    end
    tick();
    tick();
    checks++;
    if (stall_cycles_o !== exp_cnt) begin
      failures++;
      $display("FAIL perf_count: cnt=%0d expected %0d", stall_cycles_o, exp_cnt);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_stall_priority();
    test_ex_stall();
    test_exception_idle();
    test_pend();
    test_reset_in_pend();
    test_perf_cnt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
